// File: rtl/divisor_segmentado_param.sv
// divisor_segmentado_param
// Fully pipelined restoring integer divider, one operation per cycle.
// Pipeline: input stage, WIDTH/BITS_PER_STAGE iteration stages, output stage.
// Ports:
//   CLK, RSTa (async, active-high)   clock and reset
//   Start, Signed, Num, Den, Tag     operation request (sampled when Stall=0)
//   Stall                            freezes every register and all outputs
//   Done, Coc, Res, Tag_out, DivZero result (quotient, remainder, tag, /0 flag)
//   Busy                             OR of all internal stage valids
module divisor_segmentado_param #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Num,
  input  logic [WIDTH-1:0] Den,
  input  logic [TAG_W-1:0] Tag,
  input  logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Coc,
  output logic [WIDTH-1:0] Res,
  output logic [TAG_W-1:0] Tag_out,
  output logic             DivZero,
  output logic             Busy
);
  localparam int N = WIDTH / BITS_PER_STAGE;

  // Index 0 is the input stage, index k (1..N) is the output of iteration stage k.
  logic             s_valid_q [0:N];
  logic             s_valid_d [0:N];
  logic [TAG_W-1:0] s_tag_q   [0:N];
  logic [TAG_W-1:0] s_tag_d   [0:N];
  logic             s_dz_q    [0:N];
  logic             s_dz_d    [0:N];
  logic             s_sn_q    [0:N];
  logic             s_sn_d    [0:N];
  logic             s_sd_q    [0:N];
  logic             s_sd_d    [0:N];
  logic [WIDTH-1:0] s_a_q     [0:N];
  logic [WIDTH-1:0] s_a_d     [0:N];
  logic [WIDTH-1:0] s_q_q     [0:N];
  logic [WIDTH-1:0] s_q_d     [0:N];
  // The divisor is not needed after the last iteration stage.
  logic [WIDTH-1:0] s_m_q     [0:N-1];
  logic [WIDTH-1:0] s_m_d     [0:N-1];

  logic             done_q, done_d;
  logic [WIDTH-1:0] coc_q, coc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;
  logic             divzero_q, divzero_d;

  logic num_neg, den_neg;

  // Input stage: sign bits and magnitudes.
  always_comb begin
    num_neg = Signed & Num[WIDTH-1];
    den_neg = Signed & Den[WIDTH-1];
  end

  assign s_valid_d[0] = Start;
  assign s_tag_d[0]   = Tag;
  assign s_dz_d[0]    = (Den == '0);
  assign s_sn_d[0]    = num_neg;
  assign s_sd_d[0]    = den_neg;
  assign s_a_d[0]     = '0;
  assign s_q_d[0]     = num_neg ? -Num : Num;
  assign s_m_d[0]     = den_neg ? -Den : Den;

  // Iteration stages. With a zero divisor every step subtracts nothing, so Q
  // fills with ones and A ends up holding |Num|; the output stage relies on that
  // to rebuild the original dividend as the remainder.
  for (genvar gi = 1; gi <= N; gi++) begin : g_iter
    logic [WIDTH-1:0] a_v;
    logic [WIDTH-1:0] q_v;
    logic [WIDTH:0]   sh_v;
    logic [WIDTH+1:0] t_v;

    always_comb begin
      a_v  = s_a_q[gi-1];
      q_v  = s_q_q[gi-1];
      sh_v = '0;
      t_v  = '0;
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
        sh_v = {a_v, q_v[WIDTH-1]};
        q_v  = {q_v[WIDTH-2:0], 1'b0};
        t_v  = {1'b0, sh_v} - {2'b00, s_m_q[gi-1]};
        // A non-negative difference is always below the divisor, so its top two bits are zero.
        if (t_v[WIDTH+1:WIDTH] == 2'b00) begin
          a_v    = t_v[WIDTH-1:0];
          q_v[0] = 1'b1;
        end else begin
          a_v = sh_v[WIDTH-1:0];
        end
      end
    end

    assign s_valid_d[gi] = s_valid_q[gi-1];
    assign s_tag_d[gi]   = s_tag_q[gi-1];
    assign s_dz_d[gi]    = s_dz_q[gi-1];
    assign s_sn_d[gi]    = s_sn_q[gi-1];
    assign s_sd_d[gi]    = s_sd_q[gi-1];
    assign s_a_d[gi]     = a_v;
    assign s_q_d[gi]     = q_v;

    if (gi < N) begin : g_m
      assign s_m_d[gi] = s_m_q[gi-1];
    end
  end

  // Output stage: restore signs, apply divide-by-zero override.
  always_comb begin
    done_d    = s_valid_q[N];
    tag_out_d = s_tag_q[N];
    divzero_d = s_dz_q[N];
    res_d     = s_sn_q[N] ? -s_a_q[N] : s_a_q[N];
    if (s_dz_q[N]) begin
      coc_d = '1;
    end else if (s_sn_q[N] ^ s_sd_q[N]) begin
      coc_d = -s_q_q[N];
    end else begin
      coc_d = s_q_q[N];
    end
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      for (int i = 0; i <= N; i++) begin
        s_valid_q[i] <= 1'b0;
        s_tag_q[i]   <= '0;
        s_dz_q[i]    <= 1'b0;
        s_sn_q[i]    <= 1'b0;
        s_sd_q[i]    <= 1'b0;
        s_a_q[i]     <= '0;
        s_q_q[i]     <= '0;
      end
      for (int i = 0; i < N; i++) begin
        s_m_q[i] <= '0;
      end
      done_q    <= 1'b0;
      coc_q     <= '0;
      res_q     <= '0;
      tag_out_q <= '0;
      divzero_q <= 1'b0;
    end else if (!Stall) begin
      for (int i = 0; i <= N; i++) begin
        s_valid_q[i] <= s_valid_d[i];
        s_tag_q[i]   <= s_tag_d[i];
        s_dz_q[i]    <= s_dz_d[i];
        s_sn_q[i]    <= s_sn_d[i];
        s_sd_q[i]    <= s_sd_d[i];
        s_a_q[i]     <= s_a_d[i];
        s_q_q[i]     <= s_q_d[i];
      end
      for (int i = 0; i < N; i++) begin
        s_m_q[i] <= s_m_d[i];
      end
      done_q <= done_d;
      // Result fields only move when a new result arrives.
      if (done_d) begin
        coc_q     <= coc_d;
        res_q     <= res_d;
        tag_out_q <= tag_out_d;
        divzero_q <= divzero_d;
      end
    end
  end

  always_comb begin
    Busy = 1'b0;
    for (int i = 0; i <= N; i++) begin
      Busy = Busy | s_valid_q[i];
    end
  end

  assign Done    = done_q;
  assign Coc     = coc_q;
  assign Res     = res_q;
  assign Tag_out = tag_out_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_divisor_segmentado_param.sv
// Scoreboard bench for divisor_segmentado_param: a 16/1 instance with directed
// vectors, streaming with stall and reset, plus a 32/4 instance with a sweep.
module tb_divisor_segmentado_param;
  localparam int L1 = 18;
  localparam int L2 = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, one bit per stage
  logic        start1 = 0, sgn1 = 0, stall1 = 0;
  logic [15:0] num1 = '0, den1 = '0;
  logic [3:0]  tag1 = '0;
  logic        done1, dz1, busy1;
  logic [15:0] coc1, res1;
  logic [3:0]  tag_o1;

  // 32-bit, four bits per stage
  logic        start2 = 0, sgn2 = 0, stall2 = 0;
  logic [31:0] num2 = '0, den2 = '0;
  logic [3:0]  tag2 = '0;
  logic        done2, dz2, busy2;
  logic [31:0] coc2, res2;
  logic [3:0]  tag_o2;

  divisor_segmentado_param #(.WIDTH(16), .BITS_PER_STAGE(1), .TAG_W(4)) dut1 (
    .CLK(clk), .RSTa(rst), .Start(start1), .Signed(sgn1), .Num(num1), .Den(den1),
    .Tag(tag1), .Stall(stall1), .Done(done1), .Coc(coc1), .Res(res1),
    .Tag_out(tag_o1), .DivZero(dz1), .Busy(busy1));

  divisor_segmentado_param #(.WIDTH(32), .BITS_PER_STAGE(4), .TAG_W(4)) dut2 (
    .CLK(clk), .RSTa(rst), .Start(start2), .Signed(sgn2), .Num(num2), .Den(den2),
    .Tag(tag2), .Stall(stall2), .Done(done2), .Coc(coc2), .Res(res2),
    .Tag_out(tag_o2), .DivZero(dz2), .Busy(busy2));

  typedef struct {
    logic [31:0] coc;
    logic [31:0] res;
    logic [3:0]  tag;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int checks = 0;
  int errors = 0;
  int ucyc = 0;       // unstalled edges seen by dut1
  int cyc2 = 0;       // edges seen by dut2 (never stalled)
  bit edge_live = 1'b1;
  int dones_after_rst = 0;

  logic        p_done;
  logic [15:0] p_coc, p_res;
  logic [3:0]  p_tag;
  logic        p_dz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: native integer division (truncates toward zero, remainder follows dividend).
  function automatic exp_t model(input int w, input bit s, input logic [31:0] n,
                                 input logic [31:0] d, input logic [3:0] t);
    exp_t e;
    longint mask, ln, ld, q, r;
    mask = (longint'(1) << w) - 1;
    ln = longint'(n);
    ld = longint'(d);
    if (s && n[w-1]) ln = ln - (longint'(1) << w);
    if (s && d[w-1]) ld = ld - (longint'(1) << w);
    e.tag = t;
    e.due = 0;
    if (d == 0) begin
      e.dz  = 1'b1;
      e.coc = 32'(mask);
      e.res = n;
    end else begin
      q = ln / ld;
      r = ln % ld;
      e.dz  = 1'b0;
      e.coc = 32'(q & mask);
      e.res = 32'(r & mask);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    edge_live <= !stall1;
    if (!stall1) ucyc <= ucyc + 1;
    cyc2 <= cyc2 + 1;
  end

  // Monitor for dut1: pops on each fresh Done, checks hold during stall.
  always @(negedge clk) begin
    if (!rst) begin
      if (!edge_live) begin
        chk("hold_done", done1, p_done);
        chk("hold_coc", coc1, p_coc);
        chk("hold_res", res1, p_res);
        chk("hold_tag", tag_o1, p_tag);
        chk("hold_dz", dz1, p_dz);
      end else if (done1) begin
        dones_after_rst <= dones_after_rst + 1;
        if (sb1.size() == 0) begin
          chk("spurious_done16", 1, 0);
        end else begin
          exp_t e;
          e = sb1.pop_front();
          $display("dut16 tag=%0d coc=0x%h res=0x%h dz=%0b at %0d (exp coc=0x%h res=0x%h)",
                   tag_o1, coc1, res1, dz1, ucyc, e.coc[15:0], e.res[15:0]);
          chk("coc16", coc1, e.coc[15:0]);
          chk("res16", res1, e.res[15:0]);
          chk("tag16", tag_o1, e.tag);
          chk("dz16", dz1, e.dz);
          chk("latency16", ucyc, e.due);
        end
      end
    end
    p_done <= done1;
    p_coc  <= coc1;
    p_res  <= res1;
    p_tag  <= tag_o1;
    p_dz   <= dz1;
  end

  // Monitor for dut2.
  always @(negedge clk) begin
    if (!rst && done2) begin
      if (sb2.size() == 0) begin
        chk("spurious_done32", 1, 0);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        $display("dut32 tag=%0d coc=0x%h res=0x%h dz=%0b at %0d", tag_o2, coc2, res2, dz2, cyc2);
        chk("coc32", coc2, e.coc);
        chk("res32", res2, e.res);
        chk("tag32", tag_o2, e.tag);
        chk("dz32", dz2, e.dz);
        chk("latency32", cyc2, e.due);
      end
    end
  end

  task automatic issue1(input bit s, input logic [15:0] n, input logic [15:0] d,
                        input logic [3:0] t, input logic [15:0] ec, input logic [15:0] er,
                        input bit edz);
    exp_t e;
    start1 = 1'b1; sgn1 = s; num1 = n; den1 = d; tag1 = t;
    e.coc = {16'h0, ec}; e.res = {16'h0, er}; e.tag = t; e.dz = edz; e.due = ucyc + L1;
    sb1.push_back(e);
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic issue1m(input bit s, input logic [15:0] n, input logic [15:0] d, input logic [3:0] t);
    exp_t e;
    e = model(16, s, {16'h0, n}, {16'h0, d}, t);
    issue1(s, n, d, t, e.coc[15:0], e.res[15:0], e.dz);
  endtask

  task automatic issue2(input bit s, input logic [31:0] n, input logic [31:0] d, input logic [3:0] t);
    exp_t e;
    e = model(32, s, n, d, t);
    e.due = cyc2 + L2;
    start2 = 1'b1; sgn2 = s; num2 = n; den2 = d; tag2 = t;
    sb2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic drain1();
    for (int i = 0; i < 300 && sb1.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain16", sb1.size(), 0);
  endtask

  task automatic drain2();
    for (int i = 0; i < 300 && sb2.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain32", sb2.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_done", done1, 0);
    chk("rst_coc", coc1, 0);
    chk("rst_res", res1, 0);
    chk("rst_tag", tag_o1, 0);
    chk("rst_dz", dz1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_busy32", busy2, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, back to back
    issue1(0, 16'd100,  16'd7,    4'd3,  16'd14,   16'd2,    0);
    issue1(0, 16'hFFFF, 16'h0002, 4'd4,  16'h7FFF, 16'd1,    0);
    issue1(1, 16'hFF9C, 16'd7,    4'd5,  16'hFFF2, 16'hFFFE, 0);
    issue1(1, 16'd100,  16'hFFF9, 4'd6,  16'hFFF2, 16'd2,    0);
    issue1(1, 16'hFF9C, 16'hFFF9, 4'd7,  16'd14,   16'hFFFE, 0);
    issue1(1, 16'h8000, 16'hFFFF, 4'd8,  16'h8000, 16'd0,    0);
    issue1(0, 16'd1234, 16'd0,    4'd9,  16'hFFFF, 16'd1234, 1);
    issue1(1, 16'd1234, 16'd0,    4'd10, 16'hFFFF, 16'd1234, 1);
    issue1(1, 16'hFFFB, 16'd0,    4'd11, 16'hFFFF, 16'hFFFB, 1);
    issue1(0, 16'hFF9C, 16'd7,    4'd12, 16'h2484, 16'd0,    0);
    drain1();
    chk("idle_busy", busy1, 0);

    // Streaming with a 3-cycle stall while results are emerging
    for (int i = 0; i < 20; i++) begin
      if (i == 18) begin
        stall1 = 1'b1;
        start1 = 1'b1; sgn1 = 1'b0; num1 = 16'hDEAD; den1 = 16'd3; tag1 = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_busy", busy1, 1);
        stall1 = 1'b0;
        start1 = 1'b0;
      end
      issue1m(1'($urandom), 16'($urandom), 16'($urandom_range(0, 16'hFFFF)), 4'(i % 16));
    end
    drain1();

    // Reset in the middle of five operations
    for (int i = 0; i < 5; i++) issue1m(0, 16'(1000 + i), 16'(3 + i), 4'(i));
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_coc", coc1, 0);
    chk("mid_rst_res", res1, 0);
    chk("mid_rst_tag", tag_o1, 0);
    chk("mid_rst_dz", dz1, 0);
    chk("mid_rst_busy", busy1, 0);
    sb1.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    dones_after_rst = 0;
    repeat (L1 + 5) @(posedge clk);
    #1;
    chk("no_done_after_rst", dones_after_rst, 0);
    issue1(0, 16'd81, 16'd9, 4'd5, 16'd9, 16'd0, 0);
    drain1();

    // Wide configuration sweep
    for (int i = 0; i < 10000; i++) begin
      bit s;
      logic [31:0] n, d;
      int sel;
      s = 1'($urandom);
      n = $urandom;
      d = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) d = '0;
      if (sel == 1) begin s = 1'b1; n = 32'h8000_0000; d = 32'hFFFF_FFFF; end
      if (sel == 2) d = 32'($urandom_range(1, 20));
      if (sel == 3) d = {16'h0, d[15:0]};
      issue2(s, n, d, 4'(i % 16));
    end
    drain2();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divisor_segmentado_param.md
# divisor_segmentado_param

Parametrised pipelined integer divider. It is the next generation of the team's fully-segmented divider, with these additions:
- configurable width;
- configurable iterations per pipeline stage;
- per-operation signed/unsigned mode;
- divide-by-zero flagging;
- a tag carried alongside each operation;
- a global stall.

It accepts one division per cycle and sits between an operand source and a result consumer that may need to hold the pipeline.

## Interface
- `WIDTH`, default 16: operand/result width in bits, ≥ 2.
- `BITS_PER_STAGE`, default 1: restoring iterations per register stage; must divide `WIDTH`.
- `TAG_W`, default 4: width of the user tag.
- `CLK`, in, 1: clock; all registers rise-edge triggered.
- `RSTa`, in, 1: reset, asynchronous, active-high.
- `Start`, in, 1: operand valid; sampled on rising edge when `Stall`=0.
- `Signed`, in, 1: 1 = two's-complement operation, 0 = unsigned.
- `Num`, in, `WIDTH`: dividend.
- `Den`, in, `WIDTH`: divisor.
- `Tag`, in, `TAG_W`: opaque ID, returned unchanged with the result.
- `Stall`, in, 1: 1 freezes every pipeline register and all outputs.
- `Done`, out, 1: result valid, high for one unstalled cycle per operation.
- `Coc`, out, `WIDTH`: quotient.
- `Res`, out, `WIDTH`: remainder.
- `Tag_out`, out, `TAG_W`: tag of the result.
- `DivZero`, out, 1: `Den` was 0 for this result.
- `Busy`, out, 1: OR of all internal stage valids.

## Operation
- Let N = `WIDTH`/`BITS_PER_STAGE`. The pipeline is: input stage, N iteration stages, output stage.
- **Input stage.** Captures valid, `Tag`, `DivZero`=(`Den`==0), sign bits and magnitudes:
  - When `Signed`=1, negative operands are replaced by their two's-complement negation.
  - When `Signed`=0, both sign bits are forced to 0.
- **Iteration stage.** Performs `BITS_PER_STAGE` restoring steps, each one:
  - shift {A,Q} left by 1;
  - T = A − M, computed at `WIDTH`+1 bits;
  - if T ≥ 0, then A=T and Q[0]=1; otherwise restore, Q[0]=0.
  - A starts at 0. Q starts at |Num|.
- **Output stage.**
  - `Coc` = −Q when SignNum XOR SignDen, else Q.
  - `Res` = −A when SignNum, else A.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
- **Divide by zero** (`DivZero`=1, overrides arithmetic):
  - `Coc` = all ones.
  - `Res` = original `Num` (the stored sign is used to rebuild it).
- **Signed MIN / −1.** The arithmetic wraps: `Coc` = MIN, `Res` = 0. No overflow flag.
- **Stall.**
  - While `Stall`=1, no register changes, and `Start` and operands are ignored (not captured). The source must hold its request.
  - `Done`, `Coc`, `Res`, `Tag_out` and `DivZero` keep their values through the stall.
  - A `Done` asserted when the stall begins stays high until the first unstalled edge, then drops unless the next result arrives.
- Operations never reorder. Every accepted `Start` produces exactly one `Done`, unless reset intervenes.

## Timing
- Latency is L = N+2 unstalled rising edges from the `Start` sample to `Done`=1. Defaults: L=18 for 16/1, L=6 for 16/4.
- Throughput is one operation per unstalled cycle. Back-to-back `Start` gives back-to-back `Done`.
- Stalled cycles add exactly their count to the latency of every in-flight operation.
- **Reset.**
  - `RSTa`=1 immediately clears all stage valids.
  - Outputs on reset: `Done`=0, `Coc`=0, `Res`=0, `Tag_out`=0, `DivZero`=0, `Busy`=0.
  - Operations in flight are discarded; none produce a `Done`.
  - First capture is possible on the first rising edge after `RSTa` falls.
- Reset takes priority over `Stall`.
- Coincident `Start` and `Stall` mean no capture.
- Data registers without a valid may hold any value. Outputs other than `Done` are meaningful only while `Done`=1, except that they are 0 after reset.

## Test plan
- **Unsigned.** `WIDTH`=16, `BITS_PER_STAGE`=1, `Signed`=0, `Num`=100, `Den`=7, `Tag`=3 → after 18 edges: `Done`=1, `Coc`=14, `Res`=2, `Tag_out`=3, `DivZero`=0. Repeat with `Num`=0xFFFF, `Den`=0x0002 → `Coc`=0x7FFF, `Res`=1.
- **Signed sign combinations.**
  - −100/7 → `Coc`=0xFFF2, `Res`=0xFFFE.
  - 100/−7 → `Coc`=0xFFF2, `Res`=2.
  - −100/−7 → `Coc`=14, `Res`=0xFFFE.
  - 0x8000/0xFFFF → `Coc`=0x8000, `Res`=0.
- **Divide by zero.** 1234/0, either mode → `DivZero`=1, `Coc`=0xFFFF, `Res`=1234. In signed mode, −5/0 → `Res`=0xFFFB.
- **Streaming with stall.** 20 consecutive random operations with tags 0..15 wrapping, then `Stall`=1 for 3 cycles mid-stream:
  - results match a reference model in order;
  - results match tags;
  - every `Done` in the affected window is delayed by exactly 3 cycles;
  - outputs are held during the stall;
  - a `Start` presented only during the stall produces no result.
- **Reset mid-operation.** Issue 5 operations, assert `RSTa` 4 cycles later:
  - all outputs go to 0 and `Busy`=0 asynchronously;
  - no `Done` for the discarded operations;
  - an operation started after reset (81/9 → `Coc`=9, `Res`=0) completes at latency L.
- **Alternate configuration.** `WIDTH`=32, `BITS_PER_STAGE`=4: latency 10, and a randomised signed/unsigned sweep of 10k operations including `Den`=0 and MIN/−1 matches the model.
